sweep_controller: RTL
=====================

Name: sweep_controller

Overview:
Sequencer for a combinational evaluation box (a BITS-wide candidate in, 1-bit result out).
- Steps a candidate vector exhaustively from 0 to 2^BITS-1.
- Holds each candidate for a programmable settle time, then samples the box result.
- Records whether any candidate hit, the first hit and the total hit count.
- Sits between the board top (start button, LEDs) and the evaluation box; it replaces the free-running counter and sticky latch.

Parameters:
BITS, 4, candidate vector width; sweep covers 2^BITS values; legal 1..16
SETTLE_CYCLES, 4, cycles each candidate is held before sampling; legal >= 1
TIMER_W, $clog2(SETTLE_CYCLES+1), settle timer width (derived, do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin sweep; honoured only in IDLE or DONE
abort  in  1  cancel a sweep in progress
result_in  in  1  evaluation box output for current cand
cand  out  BITS  candidate vector driven to the box
busy  out  1  high while sweeping
done  out  1  sweep completed; held until next start or reset
found  out  1  at least one candidate produced result_in=1
first_hit  out  BITS  lowest candidate that hit; 0 if none
hit_count  out  BITS+1  number of hitting candidates, 0..2^BITS

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; cand=0, busy=0, done=0, found=0, first_hit=0, hit_count=0, timer=0.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE/DONE + start=1 at an edge:
  - Next state RUN; cand=0; timer=SETTLE_CYCLES-1.
  - found, first_hit and hit_count are cleared.
  - done drops on the same edge.
- RUN, timer!=0: timer decrements; cand held stable.
- RUN, timer==0 (sample cycle): result_in is sampled at that edge.
  - If sampled 1: hit_count+1; if found was 0, set found=1 and first_hit=cand.
  - If cand==2^BITS-1: go to DONE and leave cand at the final value.
  - Otherwise: cand+1 and timer reloads to SETTLE_CYCLES-1.
- Latency: each candidate occupies exactly SETTLE_CYCLES cycles. done rises at the 2^BITS*SETTLE_CYCLES-th edge after the start-accepting edge.
- start while in RUN is ignored.
- abort in RUN: go to IDLE at the next edge.
  - The result sample in that cycle is discarded, even on a sample cycle.
  - done stays 0; partial found, first_hit and hit_count remain visible; cand holds.
  - abort takes priority over start and over the sample.
- abort in IDLE or DONE has no effect.
- hit_count arithmetic is BITS+1 wide and cannot overflow (max 2^BITS).
- cand increment uses no wrap logic; the terminal compare prevents wrap.
- result_in is assumed combinationally derived from cand and stable by the sample edge; no synchronizer.

Optional Feature:
SWEEP_STOP_ON_HIT_EN
- Defined: on the first sampled hit, the controller goes to DONE immediately.
  - found=1, first_hit=cand, hit_count=1, cand holds the hitting value.
  - A no-hit sweep still ends at 2^BITS-1 with found=0.
- Undefined: full exhaustive sweep as described above; stop logic is absent from the netlist.

Decomposition:
- Package sweep_pkg holds:
  - state enum sweep_state_t {IDLE, RUN, DONE}
  - localparam helpers for terminal count (2^BITS-1) and hit_count width
- One natural sub-module: sweep_settle_timer.
  - Loadable down-counter with load, en, value and zero outputs.
  - Instantiated once.
- Candidate, statistics and FSM stay in sweep_controller.

Test Plan:
- BITS=3, SETTLE=2, result_in=&cand; pulse start -> cand steps 0..7, two cycles each; done=1 at edge 16; found=1, first_hit=7, hit_count=1, busy=0.
- BITS=3, SETTLE=1, result_in=cand[0] -> found=1, first_hit=1, hit_count=4, done at edge 8.
- result_in tied 0 -> done=1, found=0, first_hit=0, hit_count=0, cand=7.
- Abort during RUN:
  - Stimulus: result_in=cand[1], SETTLE=2; assert abort on the sample cycle of cand=3.
  - Response: IDLE next cycle; hit_count=1 (cand 2 only); done=0; start during RUN earlier ignored.
- Reset mid-sweep at cand=5 -> all outputs 0 asynchronously, before the next clk edge; restart via start then behaves as the first test.
- With SWEEP_STOP_ON_HIT_EN, result_in=(cand==5), BITS=3, SETTLE=1 -> done at edge 6, cand=5, first_hit=5, hit_count=1; start from DONE clears stats and resweeps.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive candidate sweep controller.
package sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;

  // Highest candidate value for a given vector width (2^bits - 1).
  function automatic int unsigned term_count(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // hit_count must represent 0..2^bits inclusive.
  function automatic int unsigned hit_count_w(input int unsigned bits);
    return bits + 32'd1;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that paces how long each candidate is held before sampling.
module sweep_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/sweep_controller.sv
// Steps a candidate vector 0..2^BITS-1, holds each for SETTLE_CYCLES, samples result_in
// and records found / first_hit / hit_count. Optional macro: SWEEP_STOP_ON_HIT_EN.
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int BITS          = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMER_W       = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            result_in,
  output logic [BITS-1:0] cand,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [BITS-1:0] first_hit,
  output logic [BITS:0]   hit_count
);

  localparam logic [BITS-1:0] LAST = BITS'(term_count(BITS));
  localparam int unsigned     HC_W = hit_count_w(BITS);
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

  sweep_state_t state, nxt_state;

  logic               timer_load;
  logic               timer_en;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  logic start_acc;
  logic sample_hit;
  logic cand_inc;

  sweep_settle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (RELOAD),
    .en         (timer_en),
    .value      (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state  = state;
    start_acc  = 1'b0;
    sample_hit = 1'b0;
    cand_inc   = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state  = RUN;
          start_acc  = 1'b1;
          timer_load = 1'b1;
        end
      end
      RUN: begin
        timer_en = (timer_value != '0);
        // abort discards the sample even when it lands on the sample cycle
        if (abort) begin
          nxt_state = IDLE;
        end else if (timer_zero) begin
          sample_hit = result_in;
          if (cand == LAST) begin
            nxt_state = DONE;
`ifdef SWEEP_STOP_ON_HIT_EN
          end else if (result_in) begin
            nxt_state = DONE;
`endif
          end else begin
            cand_inc   = 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= '0;
      found     <= 1'b0;
      first_hit <= '0;
      hit_count <= '0;
    end else if (start_acc) begin
      cand      <= '0;
      found     <= 1'b0;
      first_hit <= '0;
      hit_count <= '0;
    end else begin
      if (sample_hit) begin
        hit_count <= hit_count + HC_W'(1);
        if (!found) begin
          found     <= 1'b1;
          first_hit <= cand;
        end
      end
      if (cand_inc) begin
        cand <= cand + BITS'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
